// File: rtl/mv_pattern_bars_if.sv
// Video stream bundle for mv_pattern_bars: timing strobes and coordinates in,
// delayed strobes and RGB pixels out.
interface mv_pattern_bars_if #(
  parameter int unsigned COORD_W = 12,
  parameter int unsigned COLOR_W = 8
);
  logic               timing_hs;
  logic               timing_vs;
  logic               timing_de;
  logic [COORD_W-1:0] timing_x;
  logic [COORD_W-1:0] timing_y;
  logic               hs;
  logic               vs;
  logic               de;
  logic [COLOR_W-1:0] rgb_r;
  logic [COLOR_W-1:0] rgb_g;
  logic [COLOR_W-1:0] rgb_b;

  modport master (
    output timing_hs, timing_vs, timing_de, timing_x, timing_y,
    input  hs, vs, de, rgb_r, rgb_g, rgb_b
  );

  modport slave (
    input  timing_hs, timing_vs, timing_de, timing_x, timing_y,
    output hs, vs, de, rgb_r, rgb_g, rgb_b
  );
endinterface

// File: rtl/mv_pattern_bars.sv
// Colour-bar test-pattern generator (rows / columns / checker / scrolling rows).
// Optional greyscale ramp output enabled by defining PATTERN_GRAY_EN.
module mv_pattern_bars #(
  parameter int unsigned BAR_LOG2 = 3,
  parameter int unsigned COORD_W  = 12,
  parameter int unsigned COLOR_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  input  logic [1:0]  mode,
  input  logic [7:0]  frame_div,
`ifdef PATTERN_GRAY_EN
  input  logic        gray_en,
`endif
  mv_pattern_bars_if.slave vid
);
  localparam int unsigned N = 1 << BAR_LOG2;

  typedef enum logic [1:0] {
    MODE_ROWS   = 2'd0,
    MODE_COLS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  // Bar boundaries k*w (k = 1..N-1) are constant multiples of static config,
  // so the bar index is a count of boundaries passed instead of a divide.
  logic [15:0] bnd_x [N-1];
  logic [15:0] bnd_y [N-1];
  logic        wx_nz, wy_nz;

  always_ff @(posedge clk) begin
    wx_nz <= |(hactive >> BAR_LOG2);
    wy_nz <= |(vactive >> BAR_LOG2);
    for (int unsigned k = 1; k < N; k++) begin
      bnd_x[k-1] <= 16'(k * 32'(hactive >> BAR_LOG2));
      bnd_y[k-1] <= 16'(k * 32'(vactive >> BAR_LOG2));
    end
  end

  mode_e               mode_q;
  logic [BAR_LOG2-1:0] scroll_off;
  logic [7:0]          frame_cnt;
  logic                fe;

  logic [BAR_LOG2-1:0] bx, by, idx;
  logic [2:0]          pal;
  logic [COLOR_W-1:0]  pix_r, pix_g, pix_b;

  assign fe = vid.timing_vs & ~vid.vs;

  always_comb begin
    bx = '0;
    by = '0;
    for (int unsigned k = 1; k < N; k++) begin
      if (wx_nz && (32'(vid.timing_x) >= 32'(bnd_x[k-1]))) bx = bx + BAR_LOG2'(1);
      if (wy_nz && (32'(vid.timing_y) >= 32'(bnd_y[k-1]))) by = by + BAR_LOG2'(1);
    end
  end

  always_comb begin
    idx = '0;
    unique case (mode_q)
      MODE_ROWS:   idx = by;
      MODE_COLS:   idx = bx;
      MODE_CHECK:  idx = bx ^ by;
      MODE_SCROLL: idx = by + scroll_off;
      default:     idx = by;
    endcase
  end

  // Palette bit pattern: red off for 2,3,6,7; green off for 4..7; blue off for odd.
  always_comb begin
    pal   = 3'(idx);
    pix_r = {COLOR_W{~pal[1]}};
    pix_g = {COLOR_W{~pal[2]}};
    pix_b = {COLOR_W{~pal[0]}};
`ifdef PATTERN_GRAY_EN
    if (gray_en) begin
      for (int unsigned i = 0; i < COLOR_W; i++) begin
        pix_r[COLOR_W-1-i] = idx[BAR_LOG2-1-(i % BAR_LOG2)];
      end
      pix_g = pix_r;
      pix_b = pix_r;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.hs     <= 1'b0;
      vid.vs     <= 1'b0;
      vid.de     <= 1'b0;
      vid.rgb_r  <= '0;
      vid.rgb_g  <= '0;
      vid.rgb_b  <= '0;
      mode_q     <= MODE_ROWS;
      scroll_off <= '0;
      frame_cnt  <= '0;
    end else begin
      vid.hs <= vid.timing_hs;
      vid.vs <= vid.timing_vs;
      vid.de <= vid.timing_de;
      if (vid.timing_de) begin
        vid.rgb_r <= pix_r;
        vid.rgb_g <= pix_g;
        vid.rgb_b <= pix_b;
      end else begin
        vid.rgb_r <= '0;
        vid.rgb_g <= '0;
        vid.rgb_b <= '0;
      end
      if (fe) begin
        mode_q <= mode_e'(mode);
        if (frame_cnt == frame_div) begin
          frame_cnt  <= '0;
          scroll_off <= scroll_off + BAR_LOG2'(1);
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mv_pattern_bars.sv
// Self-checking bench for mv_pattern_bars: directed cases then random pixels
// against a division-based reference model.
module tb_mv_pattern_bars;
  localparam int BL = 3;
  localparam int N  = 1 << BL;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hactive = 16'd1280;
  logic [15:0] vactive = 16'd720;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  frame_div = 8'd0;
  logic        gray = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int m_q      = 0;

  logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  mv_pattern_bars_if #(.COORD_W(12), .COLOR_W(CW)) vid ();

  mv_pattern_bars #(.BAR_LOG2(BL), .COORD_W(12), .COLOR_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hactive   (hactive),
    .vactive   (vactive),
    .mode      (mode),
    .frame_div (frame_div),
`ifdef PATTERN_GRAY_EN
    .gray_en   (gray),
`endif
    .vid       (vid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bar(input int c, input int act);
    int w = act / N;
    int b;
    if (w == 0) return 0;
    b = c / w;
    return (b > N - 1) ? N - 1 : b;
  endfunction

  function automatic logic [23:0] expect_rgb(input int x, input int y, input bit de_i);
    int bx = bar(x, hactive);
    int by = bar(y, vactive);
    int off = (fe_cnt / (frame_div + 1)) % N;
    int idx;
    logic [63:0] rep = '0;
    logic [7:0]  g;
    if (!de_i) return 24'h0;
    case (m_q)
      0: idx = by;
      1: idx = bx;
      2: idx = bx ^ by;
      default: idx = (by + off) % N;
    endcase
    if (gray) begin
      for (int i = 0; i < CW / BL + 1; i++) rep = (rep << BL) | 64'(idx);
      g = 8'(rep >> ((CW / BL + 1) * BL - CW));
      return {g, g, g};
    end
    return PAL[idx % 8];
  endfunction

  function automatic logic [23:0] rgb_now();
    return {vid.rgb_r, vid.rgb_g, vid.rgb_b};
  endfunction

  task automatic pix(input string tag, input int x, input int y, input bit de_i);
    logic [23:0] exp = expect_rgb(x, y, de_i);
    logic hs_i = 1'($urandom);
    @(negedge clk);
    vid.timing_x  = 12'(x);
    vid.timing_y  = 12'(y);
    vid.timing_de = de_i;
    vid.timing_hs = hs_i;
    vid.timing_vs = 1'b0;
    @(posedge clk); #1;
    chk(tag, 64'(rgb_now()), 64'(exp));
    chk({tag, "_de"}, 64'(vid.de), 64'(de_i));
    chk({tag, "_hs"}, 64'(vid.hs), 64'(hs_i));
  endtask

  task automatic frame_pulse(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    vid.timing_vs = 1'b1;
    vid.timing_de = 1'b0;
    @(posedge clk); #1;
    fe_cnt++;
    m_q = int'(m);
    chk("vs_rise", 64'(vid.vs), 64'd1);
    chk("blank_rgb", 64'(rgb_now()), 64'd0);
    @(negedge clk);
    vid.timing_vs = 1'b0;
    @(posedge clk); #1;
    chk("vs_fall", 64'(vid.vs), 64'd0);
  endtask

  task automatic do_reset(input logic [7:0] fd);
    @(negedge clk);
    rst_n = 1'b0;
    vid.timing_vs = 1'b0;
    frame_div = fd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fe_cnt = 0;
    m_q = 0;
  endtask

  initial begin
    vid.timing_hs = 1'b1;
    vid.timing_vs = 1'b1;
    vid.timing_de = 1'b1;
    vid.timing_x  = '0;
    vid.timing_y  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", 64'(rgb_now()), 64'd0);
    chk("rst_de",  64'(vid.de), 64'd0);
    chk("rst_hs",  64'(vid.hs), 64'd0);
    chk("rst_vs",  64'(vid.vs), 64'd0);
    do_reset(8'd0);

    // Rows, 1280x720
    pix("m0_y89", 0, 89, 1'b1);
    pix("m0_y90", 0, 90, 1'b1);
    pix("m0_y719", 0, 719, 1'b1);

    // Columns
    frame_pulse(2'd1);
    pix("m1_x159", 159, 5, 1'b1);
    pix("m1_x160", 160, 5, 1'b1);
    pix("m1_x1279", 1279, 5, 1'b1);
    pix("m1_de0", 160, 5, 1'b0);

    // Remainder absorbed by the last bar
    vactive = 16'd724;
    frame_pulse(2'd0);
    pix("v724_y629", 0, 629, 1'b1);
    pix("v724_y630", 0, 630, 1'b1);
    pix("v724_y723", 0, 723, 1'b1);
    vactive = 16'd720;

    // Checker
    frame_pulse(2'd2);
    pix("m2_a", 200, 10, 1'b1);
    pix("m2_b", 200, 100, 1'b1);

    // Mode change mid-frame is deferred to the next frame event
    frame_pulse(2'd0);
    @(negedge clk);
    mode = 2'd1;
    pix("midchg_rows", 1279, 300, 1'b1);
    frame_pulse(2'd1);
    pix("midchg_cols", 1279, 300, 1'b1);

    // Scrolling rows, frame_div=1
    do_reset(8'd1);
    for (int f = 1; f <= 16; f++) begin
      frame_pulse(2'd3);
      if (f == 1 || f == 2 || f == 16) pix($sformatf("m3_fe%0d", f), 0, 0, 1'b1);
    end
    pix("m3_y100", 0, 100, 1'b1);

    // Asynchronous reset in mid-line
    pix("pre_rst", 0, 90, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rgb", 64'(rgb_now()), 64'd0);
    chk("async_de",  64'(vid.de), 64'd0);
    fe_cnt = 0;
    m_q = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pix("post_rst_m0", 0, 100, 1'b1);
    frame_pulse(2'd3);
    pix("post_rst_off", 0, 0, 1'b1);

    // Random pixels, modes and geometries
    do_reset(8'($urandom_range(0, 3)));
    for (int it = 0; it < 400; it++) begin
      if (it % 20 == 0) begin
        case ($urandom_range(0, 3))
          0: begin hactive = 16'd1280; vactive = 16'd720; end
          1: begin hactive = 16'($urandom_range(1, N - 1)); vactive = 16'($urandom_range(1, N - 1)); end
          default: begin hactive = 16'($urandom_range(8, 3000)); vactive = 16'($urandom_range(8, 3000)); end
        endcase
        frame_pulse(2'($urandom));
      end
      pix("rand", int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), ($urandom_range(0, 4) != 0));
    end

`ifdef PATTERN_GRAY_EN
    hactive = 16'd1280;
    vactive = 16'd720;
    frame_pulse(2'd0);
    gray = 1'b1;
    pix("gray_y0", 0, 0, 1'b1);
    pix("gray_y630", 0, 630, 1'b1);
    pix("gray_y300", 0, 300, 1'b1);
    gray = 1'b0;
    pix("gray_off", 0, 300, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
